// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the CPU run/step controller: mode encodings and
// the default debounce length for a 100 MHz board clock.
package cpu_step_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_FULL = 2'b00,
        MODE_DIV  = 2'b01,
        MODE_STEP = 2'b10,
        MODE_HALT = 2'b11
    } mode_t;

    // 10 ms of stable level at 100 MHz
    localparam int DEBOUNCE_100MHZ = 1000000;

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser followed by a stable-count
// filter. The output level only follows the button after it has differed
// from the current level for CYCLES consecutive clocks.
module btn_debounce
    import cpu_step_ctrl_pkg::*;
#(
    parameter int CYCLES = DEBOUNCE_100MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level
);

    localparam int CW = $clog2(CYCLES);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Count consecutive cycles of disagreement; flip the level once the run is long enough
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CW'(CYCLES - 1)) begin
            level <= ~level;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU run/step controller. Produces a single-cycle clock enable for a CPU
// that stays on the board clock, in full-speed, divided, single-step or
// halted mode, plus a heartbeat LED and a wrapping count of enables.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DIV_W           = 28,
    parameter int SEL_W           = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] div_sel,
    input  logic             step_btn,
    output logic             cpu_ce,
    output logic             heartbeat,
    output logic [CNT_W-1:0] ce_count,
    output logic             step_level
);

    localparam int SH_W = $clog2(DIV_W + 1);

    logic [1:0]       mode_s1;
    logic [1:0]       mode_s2;
    logic [SEL_W-1:0] sel_s1;
    logic [SEL_W-1:0] sel_s2;

    mode_t            mode_reg;
    mode_t            mode_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] reload;
    logic             ce_nxt;
    logic             hb_nxt;
    logic             mode_chg;
    logic             step_prev;
    logic             step_rise;

    // Reload value 2^min(sel, DIV_W) - 1; larger selections clamp to the full counter
    function automatic logic [DIV_W-1:0] period_reload(input logic [SEL_W-1:0] sel);
        logic [SH_W-1:0]  sh;
        logic [DIV_W:0]   pow2;
        if (32'(sel) >= 32'(DIV_W))
            sh = SH_W'(DIV_W);
        else
            sh = SH_W'(sel);
        pow2 = (DIV_W + 1)'(1) << sh;
        return DIV_W'(pow2 - 1'b1);
    endfunction

    btn_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (step_btn),
        .level (step_level)
    );

    assign reload    = period_reload(sel_s2);
    assign step_rise = step_level & ~step_prev;

    // Synchronise the switches. The mode synchroniser resets to HALT so that a
    // reset release cannot briefly present FULL before the real switch value arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_s1 <= MODE_HALT;
            mode_s2 <= MODE_HALT;
            sel_s1  <= '0;
            sel_s2  <= '0;
        end else begin
            mode_s1 <= mode;
            mode_s2 <= mode_s1;
            sel_s1  <= div_sel;
            sel_s2  <= sel_s1;
        end
    end

    // Next mode, divider, enable and heartbeat. A mode change costs one dead
    // cycle and drops any step edge seen in that cycle.
    always_comb begin
        mode_chg = (mode_t'(mode_s2) != mode_reg);
        mode_nxt = mode_reg;
        div_nxt  = div_cnt;
        ce_nxt   = 1'b0;
        if (mode_chg) begin
            mode_nxt = mode_t'(mode_s2);
            div_nxt  = reload;
        end else begin
            case (mode_reg)
                MODE_FULL: ce_nxt = 1'b1;
                MODE_DIV: begin
                    if (div_cnt == '0) begin
                        ce_nxt  = 1'b1;
                        div_nxt = reload;
                    end else begin
                        div_nxt = div_cnt - 1'b1;
                    end
                end
                MODE_STEP: ce_nxt = step_rise;
                default:   ce_nxt = 1'b0;
            endcase
        end
        case (mode_nxt)
            MODE_FULL: hb_nxt = 1'b1;
            MODE_HALT: hb_nxt = 1'b0;
            default:   hb_nxt = heartbeat ^ ce_nxt;
        endcase
    end

    // Mode register, divider, registered outputs and step edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg  <= MODE_HALT;
            div_cnt   <= '0;
            cpu_ce    <= 1'b0;
            heartbeat <= 1'b0;
            ce_count  <= '0;
            step_prev <= 1'b0;
        end else begin
            mode_reg  <= mode_nxt;
            div_cnt   <= div_nxt;
            cpu_ce    <= ce_nxt;
            heartbeat <= hb_nxt;
            step_prev <= step_level;
            if (ce_nxt)
                ce_count <= ce_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4, DIV_W=4, CNT_W=8.
// Expected values are hand-derived edge counts relative to each input change.
module tb_cpu_step_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [4:0] div_sel;
    logic       step_btn;
    logic       cpu_ce;
    logic       heartbeat;
    logic [7:0] ce_count;
    logic       step_level;

    int n_cmp = 0;
    int n_err = 0;

    cpu_step_ctrl #(
        .DIV_W           (4),
        .SEL_W           (5),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .div_sel    (div_sel),
        .step_btn   (step_btn),
        .cpu_ce     (cpu_ce),
        .heartbeat  (heartbeat),
        .ce_count   (ce_count),
        .step_level (step_level)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] bounce;
        bounce   = 5'b01101;
        rst      = 1'b1;
        mode     = 2'b11;
        div_sel  = 5'd0;
        step_btn = 1'b0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_ce", 32'(cpu_ce), 0);
        chk("rst_hb", 32'(heartbeat), 0);
        chk("rst_cnt", 32'(ce_count), 0);
        chk("rst_lvl", 32'(step_level), 0);
        rst = 1'b0;
        tick(); tick(); tick();
        chk("halt_ce", 32'(cpu_ce), 0);
        chk("halt_hb", 32'(heartbeat), 0);

        // RUN_FULL: enable from the 4th edge after the switch moves
        mode = 2'b00;
        tick(); chk("full_e1", 32'(cpu_ce), 0);
        tick(); chk("full_e2", 32'(cpu_ce), 0);
        tick(); chk("full_e3", 32'(cpu_ce), 0);
        chk("full_hb_e3", 32'(heartbeat), 1);
        tick(); chk("full_e4", 32'(cpu_ce), 1);
        chk("full_cnt_e4", 32'(ce_count), 1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("full_ce", 32'(cpu_ce), 1);
            chk("full_cnt", 32'(ce_count), 32'(1 + k));
            chk("full_hb", 32'(heartbeat), 1);
        end

        // RUN_DIV, div_sel=2: period 4
        mode    = 2'b01;
        div_sel = 5'd2;
        tick(); chk("div_tail1", 32'(ce_count), 18);
        tick(); chk("div_tail2", 32'(ce_count), 19);
        tick(); chk("div_entry", 32'(cpu_ce), 0);
        chk("div_entry_hb", 32'(heartbeat), 1);
        for (int k = 4; k <= 11; k++) begin
            tick();
            chk("div4_ce", 32'(cpu_ce), 32'(k == 7 || k == 11));
            if (k == 7) chk("div4_hb_a", 32'(heartbeat), 0);
        end
        chk("div4_cnt", 32'(ce_count), 21);
        chk("div4_hb_b", 32'(heartbeat), 1);

        // div_sel=9 clamps to 16; change lands at the next reload
        div_sel = 5'd9;
        for (int f = 1; f <= 36; f++) begin
            tick();
            chk("div16_ce", 32'(cpu_ce), 32'(f == 4 || f == 20 || f == 36));
        end
        chk("div16_cnt", 32'(ce_count), 24);
        chk("div16_hb", 32'(heartbeat), 0);

        // div_sel=0: every cycle once the running 16-period completes
        div_sel = 5'd0;
        for (int g = 1; g <= 23; g++) begin
            tick();
            chk("div1_ce", 32'(cpu_ce), 32'(g >= 16));
        end
        chk("div1_cnt", 32'(ce_count), 32);
        chk("div1_hb", 32'(heartbeat), 0);

        // STEP with a bouncy press
        mode = 2'b10;
        tick(); tick();
        chk("step_tail", 32'(ce_count), 34);
        tick(); chk("step_entry", 32'(cpu_ce), 0);
        for (int i = 0; i < 5; i++) begin
            step_btn = bounce[i];
            tick();
            chk("bounce_ce", 32'(cpu_ce), 0);
        end
        step_btn = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            chk("hold_ce", 32'(cpu_ce), 32'(k == 7));
            if (k == 5) chk("hold_lvl_early", 32'(step_level), 0);
        end
        chk("hold_lvl", 32'(step_level), 1);
        chk("hold_cnt", 32'(ce_count), 35);
        chk("hold_hb", 32'(heartbeat), 1);
        step_btn = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("release_ce", 32'(cpu_ce), 0);
        end
        chk("release_lvl", 32'(step_level), 0);
        chk("release_cnt", 32'(ce_count), 35);

        // 3-cycle glitch is filtered
        step_btn = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("glitch_lvl", 32'(step_level), 0);
        end
        step_btn = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("glitch_ce", 32'(cpu_ce), 0);
            chk("glitch_lvl", 32'(step_level), 0);
        end

        // FULL then HALT while running
        mode = 2'b00;
        for (int k = 1; k <= 6; k++) tick();
        chk("full2_ce", 32'(cpu_ce), 1);
        chk("full2_cnt", 32'(ce_count), 38);
        mode = 2'b11;
        tick(); tick();
        chk("halt_tail", 32'(ce_count), 40);
        tick();
        chk("halt_stop_ce", 32'(cpu_ce), 0);
        chk("halt_stop_hb", 32'(heartbeat), 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("halt_freeze_cnt", 32'(ce_count), 40);
            chk("halt_freeze_ce", 32'(cpu_ce), 0);
        end

        // Press in HALT, then enter STEP: no late pulse
        step_btn = 1'b1;
        for (int k = 1; k <= 10; k++) tick();
        chk("halt_press_lvl", 32'(step_level), 1);
        mode = 2'b10;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("late_edge_ce", 32'(cpu_ce), 0);
        end
        chk("late_edge_cnt", 32'(ce_count), 40);
        step_btn = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        chk("late_rel_lvl", 32'(step_level), 0);
        chk("late_rel_cnt", 32'(ce_count), 40);

        // RUN_DIV period 2, then reset mid-run
        mode    = 2'b01;
        div_sel = 5'd1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("div2_ce", 32'(cpu_ce), 32'(k == 5 || k == 7));
        end
        chk("div2_cnt", 32'(ce_count), 42);
        rst = 1'b1;
        #1;
        chk("arst_ce", 32'(cpu_ce), 0);
        chk("arst_cnt", 32'(ce_count), 0);
        chk("arst_hb", 32'(heartbeat), 0);
        chk("arst_lvl", 32'(step_level), 0);
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("post_rst_ce", 32'(cpu_ce), 32'(k == 5));
        end
        chk("post_rst_cnt", 32'(ce_count), 1);
        chk("post_rst_hb", 32'(heartbeat), 1);

        // Wrap: 256 enables return the count to 0
        rst  = 1'b1;
        mode = 2'b00;
        #1;
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("wrap_start_cnt", 32'(ce_count), 0);
        chk("wrap_start_ce", 32'(cpu_ce), 0);
        for (int k = 1; k <= 255; k++) begin
            tick();
            chk("wrap_cnt", 32'(ce_count), 32'(k));
        end
        tick();
        chk("wrap_zero", 32'(ce_count), 0);
        chk("wrap_ce", 32'(cpu_ce), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
- Parametrised CPU run/step controller for board-level top modules.
- Generates a single-cycle clock-enable, cpu_ce, for the CPU core. The CPU stays on the board clock; no derived or gated clocks.
- Modes: full speed, programmable power-of-two division, debounced single-step from a push-button, and halt.
- Also drives a heartbeat LED and a wrapping count of issued enables for debug display.

Parameters:
- DIV_W, default 28: width of the division down-counter. Maximum period is 2^DIV_W cycles.
- SEL_W, default 5: width of div_sel.
- DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept a button level (10 ms at 100 MHz). Must be ≥ 2.
- CNT_W, default 16: width of ce_count.

Ports:
- clk, input, 1: board clock.
- rst, input, 1: reset, asynchronous, active-high.
- mode, input, 2: 00 RUN_FULL, 01 RUN_DIV, 10 STEP, 11 HALT. Asynchronous (switches).
- div_sel, input, SEL_W: RUN_DIV period = 2^min(div_sel, DIV_W) cycles. Asynchronous.
- step_btn, input, 1: raw push-button, active-high, bouncy.
- cpu_ce, output, 1: one-clk enable pulse to the CPU.
- heartbeat, output, 1: toggles on each cpu_ce in RUN_DIV/STEP; constant 1 in RUN_FULL; constant 0 in HALT.
- ce_count, output, CNT_W: number of cpu_ce pulses issued, wraps modulo 2^CNT_W.
- step_level, output, 1: debounced button level, for an LED.

Behaviour:
- Reset (async assert; registers sample normally from the first clk edge after deassert):
  - cpu_ce=0, heartbeat=0, ce_count=0, step_level=0.
  - Synchronisers cleared; div counter=0; mode register=HALT.
- Input synchronisation:
  - mode, div_sel and step_btn each pass through a 2-FF synchroniser.
  - All decisions use the synchronised values. This is 2 cycles of input latency.
- Mode register: holds the synchronised mode. When the synchronised mode differs from the register, on that edge:
  - update the register;
  - reload the div counter with 2^min(div_sel,DIV_W)-1;
  - force cpu_ce=0 for that cycle;
  - clear any pending step edge.
- RUN_FULL:
  - cpu_ce=1 every cycle from the cycle after mode entry.
  - ce_count increments every cycle.
- RUN_DIV:
  - Down-counter. At 0: cpu_ce=1 and reload 2^min(div_sel,DIV_W)-1. Otherwise: decrement, cpu_ce=0.
  - div_sel=0 gives an enable every cycle.
  - A div_sel change takes effect at the next reload; no glitch or short period mid-count.
  - Clamp: div_sel ≥ DIV_W behaves as DIV_W.
- STEP:
  - On a 0→1 edge of step_level, cpu_ce=1 for exactly one cycle, the cycle after the edge is detected.
  - Holding the button produces no further pulses. Release produces none.
  - An edge that occurs in other modes never produces a pulse later.
- HALT: cpu_ce=0 always; counters hold.
- Debouncer:
  - Counter increments while the synchronised button differs from step_level; cleared when they are equal.
  - On reaching DEBOUNCE_CYCLES-1 with the difference still present: step_level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change step_level.
  - The debouncer runs in all modes.
- ce_count and heartbeat update on the same edge where cpu_ce=1 is registered. Both are registered outputs.
- Reset asserted mid-operation: all state returns to reset values immediately. After release the block is in HALT until the mode synchroniser delivers the switch value.
- Latency from a clean button press to cpu_ce: 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) cycles.

Decomposition:
- Shared package holds:
  - mode encodings MODE_FULL=2'b00, MODE_DIV=2'b01, MODE_STEP=2'b10, MODE_HALT=2'b11;
  - the default DEBOUNCE_CYCLES constant for 100 MHz.
- One sub-module, btn_debounce (parameter CYCLES). It contains the 2-FF synchroniser plus the stable-count filter and outputs a level.
- The top of cpu_step_ctrl holds the mode register, divider, edge detect and counters.

Test Plan (bench uses DEBOUNCE_CYCLES=4, DIV_W=4, CNT_W=8):
- Reset, then mode=00 for 20 cycles → cpu_ce high continuously from the 4th edge after the mode change; ce_count increments every cycle; heartbeat=1.
- mode=01, div_sel=2 → cpu_ce period exactly 4 cycles, heartbeat toggles each pulse. Set div_sel=9 → period clamps to 16. Set div_sel=0 → every cycle.
- mode=10, press step_btn with 1–2-cycle bounces, then hold 50 cycles → exactly one cpu_ce pulse, ce_count +1, step_level=1. Release → no pulse.
- mode=10, 3-cycle glitch on step_btn → step_level stays 0, no cpu_ce.
- mode=00→11 while running → cpu_ce=0 within 3 cycles; ce_count frozen. Press the button in HALT, then switch to STEP → no pulse.
- Assert rst mid-RUN_DIV for 1 cycle → all outputs 0 immediately; after release cpu_ce stays 0 until the synchronised mode arrives. Wrap test: 256 pulses → ce_count back to 0.
